act_seq_bank: RTL and testbench

- Parametrised bank of CH sequential Actel-style logic channels.
- Each channel has an AND/OR select pair driving a 4:1 data mux, followed by a register with a per-channel run-time mode: combinational, D, enable, or toggle.
- Channel modes are loaded serially through a configuration handshake.
- A scan chain across all channel registers supports test access.
- Sits at the logic-module level, one step above the single-cell combinational/sequential modules.

---
 rtl/act_seq_bank.sv | 113 +++++++++++
 tb/tb_act_seq_bank.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/act_seq_bank.sv
// act_seq_bank: CH Actel-style AND/OR-select mux channels, each with a
// run-time register mode, serial mode load and a scan chain through the regs.
module act_seq_bank #(
  parameter  int CH    = 4,
  localparam int CNT_W = $clog2(2*CH+1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [CH-1:0] a0,
  input  logic [CH-1:0] b0,
  input  logic [CH-1:0] a1,
  input  logic [CH-1:0] b1,
  input  logic [4*CH-1:0] d,
  input  logic [CH-1:0] en,
  input  logic          cfg_valid,
  input  logic          cfg_bit,
  output logic          cfg_ready,
  input  logic          cfg_restart,
  output logic          cfg_done,
  input  logic          scan_en,
  input  logic          scan_in,
  output logic          scan_out,
  output logic [CH-1:0] out
);

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2*CH);

  state_t              state_q, state_d;
  logic [2*CH-1:0]     cfg_q, cfg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH-1:0]       q_q, q_d;
  logic [CH-1:0]       m;
  logic [1:0]          mode [CH];
  logic                run;

  assign run = (state_q == RUN);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [1:0] sel;
    logic [3:0] nib;
    assign sel     = {a1[g] | b1[g], a0[g] & b0[g]};
    assign nib     = d[4*g +: 4];
    assign m[g]    = nib[sel];
    assign mode[g] = cfg_q[2*g +: 2];
    // COMB mode bypasses the register entirely
    assign out[g]  = run & ((mode[g] == 2'b00) ? m[g] : q_q[g]);
  end

  assign cfg_ready = (state_q == LOAD);
  assign cfg_done  = run;
  assign scan_out  = q_q[CH-1];

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    unique case (state_q)
      UNCFG: state_d = LOAD;
      LOAD: begin
        if (cfg_valid) begin
          cfg_d = {cfg_q[2*CH-2:0], cfg_bit};
          if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_MAX - 1'b1)
            state_d = RUN;
        end
      end
      RUN: begin
        if (cfg_restart) begin
          state_d = LOAD;
          cnt_d   = '0;
          q_d     = '0;
        end else if (scan_en) begin
          q_d[0] = scan_in;
          for (int i = 1; i < CH; i++)
            q_d[i] = q_q[i-1];
        end else begin
          for (int i = 0; i < CH; i++) begin
            unique case (mode[i])
              2'b00: q_d[i] = q_q[i];
              2'b01: q_d[i] = m[i];
              2'b10: if (en[i]) q_d[i] = m[i];
              2'b11: if (m[i]) q_d[i] = ~q_q[i];
            endcase
          end
        end
      end
      default: state_d = UNCFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= UNCFG;
      cfg_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

endmodule

// File: tb/tb_act_seq_bank.sv
// Directed bench for act_seq_bank (CH=4): reset, config load, modes,
// scan, restart priority and stray config bits.
module tb_act_seq_bank;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic [CH-1:0] a0, b0, a1, b1, en;
  logic [4*CH-1:0] d;
  logic          cfg_valid, cfg_bit, cfg_restart;
  logic          scan_en, scan_in;
  logic          cfg_ready, cfg_done, scan_out;
  logic [CH-1:0] out;

  int tests = 0;
  int fails = 0;

  act_seq_bank #(.CH(CH)) dut (
    .clk(clk), .clr(clr),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .d(d), .en(en),
    .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_restart(cfg_restart),
    .cfg_done(cfg_done), .scan_en(scan_en),
    .scan_in(scan_in), .scan_out(scan_out),
    .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    clr = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    en = '0; d = '0; cfg_valid = 1'b1; cfg_bit = 1'b1;
    cfg_restart = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
    step(); step();
    // reset state, with cfg_valid high to exercise clr priority
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h0);
    chk("rst_done", 32'(cfg_done), 32'h0);
    chk("rst_scan", 32'(scan_out), 32'h0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'h0);
    cfg_valid = 1'b0;
    clr = 1'b1;
    #1;
    chk("uncfg_ready", 32'(cfg_ready), 32'h0);
    step();
    chk("load_ready", 32'(cfg_ready), 32'h1);

    // reset mid-LOAD
    send(1'b1); send(1'b0); send(1'b1);
    chk("mid_cnt3", 32'(dut.cnt_q), 32'd3);
    clr = 1'b0; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("mid_cnt0", 32'(dut.cnt_q), 32'h0);
    chk("mid_cfg0", 32'(dut.cfg_q), 32'h0);
    chk("mid_ready0", 32'(cfg_ready), 32'h0);
    clr = 1'b1;
    step();
    chk("mid_ready1", 32'(cfg_ready), 32'h1);
    chk("mid_cnt_rel", 32'(dut.cnt_q), 32'h0);
    chk("mid_out", 32'(out), 32'h0);

    // load all DFF: 01010101 with a gap after bit 4
    send(1'b0); send(1'b1); send(1'b0); send(1'b1);
    step();
    chk("gap_cnt", 32'(dut.cnt_q), 32'd4);
    send(1'b0); send(1'b1); send(1'b0);
    chk("b7_done", 32'(cfg_done), 32'h0);
    chk("b7_ready", 32'(cfg_ready), 32'h1);
    send(1'b1);
    chk("b8_done", 32'(cfg_done), 32'h1);
    chk("b8_ready", 32'(cfg_ready), 32'h0);
    chk("b8_cfg", 32'(dut.cfg_q), 32'h55);
    chk("b8_cnt", 32'(dut.cnt_q), 32'd8);

    // DFF channel 0: sel=01 picks d[1]
    a0 = 4'b0001; b0 = 4'b0001; d = 16'h0002;
    #1;
    chk("dff_pre", 32'(out), 32'h0);
    step();
    chk("dff_post", 32'(out), 32'h1);
    a0 = '0; b0 = '0; d = '0;
    step();
    chk("dff_clear", 32'(out), 32'h0);

    // scan with functional inputs forcing m=1 everywhere
    d = 16'hFFFF; en = 4'hF; scan_en = 1'b1;
    scan_in = 1'b1; step();
    chk("scan_o1", 32'(scan_out), 32'h0);
    scan_in = 1'b0; step();
    chk("scan_o2", 32'(scan_out), 32'h0);
    scan_in = 1'b1; step();
    chk("scan_o3", 32'(scan_out), 32'h0);
    scan_in = 1'b1; step();
    chk("scan_o4", 32'(scan_out), 32'h1);
    chk("scan_q", 32'(dut.q_q), 32'hB);
    chk("scan_out_vec", 32'(out), 32'hB);

    // restart together with scan_en
    cfg_restart = 1'b1; scan_in = 1'b0;
    step();
    cfg_restart = 1'b0; scan_en = 1'b0;
    d = '0; en = '0;
    chk("rs_ready", 32'(cfg_ready), 32'h1);
    chk("rs_done", 32'(cfg_done), 32'h0);
    chk("rs_q", 32'(dut.q_q), 32'h0);
    chk("rs_out", 32'(out), 32'h0);
    chk("rs_cfg", 32'(dut.cfg_q), 32'h55);
    chk("rs_cnt", 32'(dut.cnt_q), 32'h0);

    // restart outside RUN is ignored
    cfg_restart = 1'b1;
    step();
    cfg_restart = 1'b0;
    chk("rs_load_ready", 32'(cfg_ready), 32'h1);
    chk("rs_load_cnt", 32'(dut.cnt_q), 32'h0);

    // mixed: ch3=TGL ch2=ENA ch1=DFF ch0=COMB
    send(1'b1); send(1'b1); send(1'b1); send(1'b0);
    send(1'b0); send(1'b1); send(1'b0); send(1'b0);
    chk("mix_done", 32'(cfg_done), 32'h1);
    chk("mix_cfg", 32'(dut.cfg_q), 32'hE4);
    a1 = 4'b0001; d = 16'h1104;
    #1;
    chk("mix_comb", 32'(out), 32'h1);
    step();
    chk("mix_t1", 32'(out), 32'h9);
    step();
    chk("mix_t2", 32'(out), 32'h1);
    step();
    chk("mix_t3", 32'(out), 32'h9);
    en = 4'b0100;
    step();
    chk("mix_ena", 32'(out), 32'h5);
    en = '0; d = 16'h0004;
    step();
    chk("mix_hold", 32'(out), 32'h5);

    // stray config bits in RUN
    cfg_valid = 1'b1; cfg_bit = 1'b1;
    step(); step();
    cfg_valid = 1'b0;
    chk("stray_cfg", 32'(dut.cfg_q), 32'hE4);
    chk("stray_cnt", 32'(dut.cnt_q), 32'd8);
    chk("stray_out", 32'(out), 32'h5);
    chk("stray_done", 32'(cfg_done), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
